dac_upsampler: RTL and testbench

Output-side rate converter for the audio path. It accepts 12-bit samples at the low processing rate through a valid/ready handshake. It emits one interpolated sample every OUT_PERIOD clocks toward the DAC, raising the rate by 2^INTERP_N_BITS. It sits after the pitch-correction core and is the output counterpart of the input oversampler/decimator.

---
 rtl/audio_pkg.sv | 16 +
 rtl/sample_tick_gen.sv | 30 +++
 rtl/dac_upsampler.sv | 185 ++++++++++++++++++
 tb/tb_dac_upsampler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, sample type and the
// upsampler state encoding.
package audio_pkg;

  localparam int DATA_WIDTH = 12;

  typedef logic [DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    RUN    = 2'd2,
    STARVE = 2'd3
  } ups_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate tick: one-cycle pulse every PERIOD clocks.
// The counter runs 0..PERIOD-1 from reset release, and the tick is high
// in the cycle where the count is PERIOD-1.
module sample_tick_gen #(
  parameter int PERIOD = 128
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Count up and wrap to zero on the terminal count.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dac_upsampler.sv
// Output-side rate converter: accepts samples through valid/ready and emits
// 2^INTERP_N_BITS interpolated samples per input, one every OUT_PERIOD clocks.
// Build option: define UPSAMPLER_LINEAR_EN for linear interpolation; without
// it every phase emits the previous endpoint (zero-order hold) and the
// subtractor/multiplier are not built.
//
// state  | meaning
// IDLE   | no samples yet; first accept loads curr
// PRIME  | one sample held; second accept forms the first prev/curr pair
// RUN    | interpolating prev->curr, one phase per tick; pend refills
// STARVE | segment finished with no pending sample; re-emit curr, flag underrun
module dac_upsampler #(
  parameter int DATA_WIDTH    = audio_pkg::DATA_WIDTH,
  parameter int INTERP_N_BITS = 3,
  parameter int OUT_PERIOD    = 128
) (
  input  logic                  clk_100mhz,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sample_trigger,
  output logic                  underrun
);

  import audio_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int N  = INTERP_N_BITS;
  localparam logic [N-1:0] K_LAST = '1;

  ups_state_t state, state_nxt;

  logic [DW-1:0] prev, curr, pend, interp;
  logic          pend_v;
  logic [N-1:0]  k;
  logic          tick;
  logic          accept;

  logic ld_first, ld_prime, ld_pend, xfer;
  logic emit_interp, emit_curr, k_inc, k_one, und_nxt;

  sample_tick_gen #(
    .PERIOD (OUT_PERIOD)
  ) u_tick (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .tick       (tick)
  );

  // Ready depends only on state and the registered slot flag, never on valid.
  assign data_ready = (state == IDLE) || (state == PRIME) || !pend_v;
  assign accept     = data_valid && data_ready;

`ifdef UPSAMPLER_LINEAR_EN
  logic signed [DW:0]   diff;
  logic signed [DW+N:0] prod;
  logic signed [DW+N:0] step;

  // prev + floor((curr - prev) * k / 2^N); result stays between the endpoints.
  assign diff   = $signed({1'b0, curr}) - $signed({1'b0, prev});
  assign prod   = {{N{diff[DW]}}, diff} * {{(DW+1){1'b0}}, k};
  assign step   = prod >>> N;
  assign interp = DW'({{(N+1){1'b0}}, prev} + step);
`else
  assign interp = prev;
`endif

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt   = state;
    ld_first    = 1'b0;
    ld_prime    = 1'b0;
    ld_pend     = 1'b0;
    xfer        = 1'b0;
    emit_interp = 1'b0;
    emit_curr   = 1'b0;
    k_inc       = 1'b0;
    k_one       = 1'b0;
    und_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ld_first  = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        if (accept) begin
          ld_prime  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ld_pend = accept;
        if (tick) begin
          emit_interp = 1'b1;
          k_inc       = 1'b1;
          if (k == K_LAST) begin
            if (pend_v) begin
              xfer = 1'b1;
            end else begin
              state_nxt = STARVE;
            end
          end
        end
      end
      STARVE: begin
        ld_pend = accept;
        if (tick) begin
          // Both branches emit curr: on a refill it is interp(0) of the new pair.
          emit_curr = 1'b1;
          if (pend_v) begin
            xfer      = 1'b1;
            k_one     = 1'b1;
            state_nxt = RUN;
          end else begin
            und_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Endpoints, pending slot, phase and registered outputs.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      prev           <= '0;
      curr           <= '0;
      pend           <= '0;
      pend_v         <= 1'b0;
      k              <= '0;
      data_out       <= '0;
      sample_trigger <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      sample_trigger <= tick;
      underrun       <= und_nxt;

      if (emit_interp) begin
        data_out <= interp;
      end else if (emit_curr) begin
        data_out <= curr;
      end

      if (ld_first) begin
        curr <= data_in;
      end else if (ld_prime) begin
        prev <= curr;
        curr <= data_in;
      end else if (xfer) begin
        prev <= curr;
        curr <= pend;
      end

      if (ld_prime) begin
        k <= '0;
      end else if (k_one) begin
        k <= N'(1);
      end else if (k_inc) begin
        k <= k + N'(1);
      end

      // ready is low while pend_v is set, so a refill and a drain never coincide.
      if (ld_pend) begin
        pend   <= data_in;
        pend_v <= 1'b1;
      end else if (xfer) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dac_upsampler.sv
// Self-checking bench for dac_upsampler with a sample-level reference model.
// Follows the UPSAMPLER_LINEAR_EN build option of the design.
module tb_dac_upsampler;

  localparam int DW = 12;
  localparam int NB = 3;
  localparam int OP = 8;
  localparam int L  = 1 << NB;

`ifdef UPSAMPLER_LINEAR_EN
  localparam int EXP_A[13] = '{100, 110, 120, 130, 140, 150, 160, 170, 180, 180, 180, 190, 200};
  localparam int EXP_B[24] = '{200, 187, 175, 162, 150, 137, 125, 112,
                               100, 125, 150, 175, 200, 225, 250, 275,
                               300, 312, 325, 337, 350, 362, 375, 387};
`else
  localparam int EXP_A[13] = '{100, 100, 100, 100, 100, 100, 100, 100, 180, 180, 180, 180, 180};
  localparam int EXP_B[24] = '{200, 200, 200, 200, 200, 200, 200, 200,
                               100, 100, 100, 100, 100, 100, 100, 100,
                               300, 300, 300, 300, 300, 300, 300, 300};
`endif
  localparam bit EXP_A_UND[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

  logic          clk_100mhz = 1'b0;
  logic          rst_n      = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data_in    = '0;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          sample_trigger;
  logic          underrun;

  int checks   = 0;
  int failures = 0;

  dac_upsampler #(
    .DATA_WIDTH    (DW),
    .INTERP_N_BITS (NB),
    .OUT_PERIOD    (OP)
  ) dut (
    .clk_100mhz     (clk_100mhz),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .data_out       (data_out),
    .sample_trigger (sample_trigger),
    .underrun       (underrun)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // ---------------- reference model ----------------
  int m_cyc;          // clocks since reset release, modulo OP
  int m_seen;         // accepted samples so far, saturating at 2
  int m_prev, m_curr, m_k, m_out;
  bit m_starving, m_trig, m_und, m_last_acc;
  int m_pend[$];
  int log_val[$];
  bit log_und[$];

  function automatic int interp_ref(int p, int c, int kk);
`ifdef UPSAMPLER_LINEAR_EN
    int num = (c - p) * kk;
    int q   = (num >= 0) ? num / L : -((-num + L - 1) / L);
    return p + q;
`else
    return p + 0 * kk;
`endif
  endfunction

  function automatic bit m_ready();
    return (m_seen < 2) || (m_pend.size() == 0);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_seen = 0; m_prev = 0; m_curr = 0; m_k = 0; m_out = 0;
    m_starving = 0; m_trig = 0; m_und = 0; m_last_acc = 0;
    m_pend.delete();
  endtask

  always @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit is_tick;
      bit acc;
      is_tick    = (m_cyc == OP - 1);
      m_cyc      = (m_cyc + 1) % OP;
      acc        = data_valid && m_ready();
      m_last_acc = acc;
      m_trig     = is_tick;
      m_und      = 0;
      if (is_tick) begin
        if (m_seen < 2) begin
          // nothing to interpolate yet: hold the previous output
        end else if (!m_starving) begin
          m_out = interp_ref(m_prev, m_curr, m_k);
          if (m_k == L - 1) begin
            m_k = 0;
            if (m_pend.size() > 0) begin
              m_prev = m_curr;
              m_curr = m_pend.pop_front();
            end else begin
              m_starving = 1;
            end
          end else begin
            m_k = m_k + 1;
          end
        end else begin
          m_out = m_curr;
          if (m_pend.size() > 0) begin
            m_prev = m_curr;
            m_curr = m_pend.pop_front();
            m_k = 1;
            m_starving = 0;
          end else begin
            m_und = 1;
          end
        end
        log_val.push_back(m_out);
        log_und.push_back(m_und);
      end
      if (acc) begin
        if (m_seen == 0) begin
          m_curr = int'(data_in);
          m_seen = 1;
        end else if (m_seen == 1) begin
          m_prev = m_curr;
          m_curr = int'(data_in);
          m_k = 0;
          m_seen = 2;
        end else begin
          m_pend.push_back(int'(data_in));
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_100mhz) begin
    chk("data_ready", 32'(data_ready), 32'(m_ready()));
    chk("sample_trigger", 32'(sample_trigger), 32'(m_trig));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("data_out", 32'(data_out), 32'(m_out));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int x);
    int n;
    n = 0;
    data_valid = 1'b1;
    data_in    = DW'(x);
    do begin
      @(negedge clk_100mhz);
      n++;
    end while (!m_last_acc && n < 300);
    checks++;
    if (!m_last_acc) begin
      failures++;
      $display("FAIL send_accept value=%0d accepted=0 expected=1", x);
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_emits(input int n);
    int c;
    c = 0;
    while (log_val.size() < n && c < n * OP * 2 + 100) begin
      @(negedge clk_100mhz);
      c++;
    end
    checks++;
    if (log_val.size() < n) begin
      failures++;
      $display("FAIL wait_emits got=%0d expected=%0d", log_val.size(), n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_trigger"}, 32'(sample_trigger), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_ready"}, 32'(data_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int trig_cnt;
    int rv;

    rst_n = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle: triggers keep coming with the held zero output.
    trig_cnt = 0;
    repeat (24) begin
      @(negedge clk_100mhz);
      if (sample_trigger) trig_cnt++;
    end
    chk("idle_trigger_count", 32'(trig_cnt), 32'd3);
    chk("idle_data_out", 32'(data_out), 32'd0);

    // Ramp 100->180, then starvation, then recovery with 260.
    send(100);
    send(180);
    log_val.delete();
    log_und.delete();
    wait_emits(10);
    send(260);
    wait_emits(13);
    for (int i = 0; i < 13; i++) begin
      if (i < log_val.size()) begin
        chk($sformatf("seqA_val[%0d]", i), 32'(log_val[i]), 32'(EXP_A[i]));
        chk($sformatf("seqA_und[%0d]", i), 32'(log_und[i]), 32'(EXP_A_UND[i]));
      end
    end

    // Asynchronous reset in the middle of RUN.
    @(posedge clk_100mhz);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    repeat (2) @(negedge clk_100mhz);
    rst_n = 1'b1;

    // Falling ramp, then a stalled sample held on the bus until the slot frees.
    send(200);
    send(100);
    log_val.delete();
    log_und.delete();
    send(300);
    chk("stall_ready_low", 32'(data_ready), 32'd0);
    send(400);
    wait_emits(24);
    for (int i = 0; i < 24; i++) begin
      if (i < log_val.size()) begin
        chk($sformatf("seqB_val[%0d]", i), 32'(log_val[i]), 32'(EXP_B[i]));
        chk($sformatf("seqB_und[%0d]", i), 32'(log_und[i]), 32'd0);
      end
    end

    // Randomized traffic around the nominal input rate, with one async reset.
    @(negedge clk_100mhz);
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        #3 rst_n = 1'b0;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        rst_n = 1'b1;
      end
      data_valid = ($urandom_range(0, 47) == 0);
      rv = $urandom_range(0, 5);
      if (rv == 0)      data_in = '0;
      else if (rv == 1) data_in = '1;
      else              data_in = DW'($urandom_range(0, (1 << DW) - 1));
      @(negedge clk_100mhz);
    end
    data_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout reached=1 expected=0");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
